// File: rtl/ssp_slave_port_if.sv
// ssp_slave_port_if
//  Bundles the CPU bus and the SSP serial pins of the SSP slave endpoint.
//  Signals:
//   PSEL, PWRITE, PWDATA[N]   bus select, direction (1=write TX FIFO), write data
//   PRDATA[N]                 RX FIFO head, 0 when empty
//   SSPCLKIN, SSPFSSIN        serial clock and frame sync from the remote master
//   SSPRXD / SSPTXD           serial data in / out, MSB first
//   SSPOE_B                   active-low TX pad enable
//   SSPTXINTR, SSPRXINTR      TX FIFO full, RX FIFO not empty
//   SSPRXOVR                  sticky RX overrun
//  Modports: slave (the endpoint), master (bus/pin driver side).
`timescale 1ns/1ps
interface ssp_slave_port_if #(
  parameter int N = 8
);
  logic         PSEL;
  logic         PWRITE;
  logic [N-1:0] PWDATA;
  logic [N-1:0] PRDATA;
  logic         SSPCLKIN;
  logic         SSPFSSIN;
  logic         SSPRXD;
  logic         SSPTXD;
  logic         SSPOE_B;
  logic         SSPTXINTR;
  logic         SSPRXINTR;
  logic         SSPRXOVR;

  modport slave (
    input  PSEL, PWRITE, PWDATA, SSPCLKIN, SSPFSSIN, SSPRXD,
    output PRDATA, SSPTXD, SSPOE_B, SSPTXINTR, SSPRXINTR, SSPRXOVR
  );

  modport master (
    output PSEL, PWRITE, PWDATA, SSPCLKIN, SSPFSSIN, SSPRXD,
    input  PRDATA, SSPTXD, SSPOE_B, SSPTXINTR, SSPRXINTR, SSPRXOVR
  );
endinterface

// File: rtl/ssp_slave_port.sv
// ssp_slave_port
//  TI-format SSP slave endpoint. Oversamples the remote master's serial clock,
//  frame sync and data on PCLK, de-serialises N-bit frames into an RX FIFO and
//  at the same time serialises TX FIFO words onto SSPTXD. The CPU pushes the TX
//  FIFO and pops the RX FIFO through the PSEL/PWRITE bus.
//  Ports:
//   PCLK   sole clock, rising edge
//   CLEAR  synchronous active-high reset
//   bus    ssp_slave_port_if.slave (bus signals, serial pins, status flags)
`timescale 1ns/1ps
module ssp_slave_port #(
  parameter int N     = 8,
  parameter int DEPTH = 4
) (
  input logic              PCLK,
  input logic              CLEAR,
  ssp_slave_port_if.slave  bus
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam int BW = (N > 1) ? $clog2(N) : 1;

  typedef enum logic {IDLE, SHIFT} state_t;

  state_t          state_q, state_d;
  logic [2:0]      sclk_sync;
  logic [1:0]      fss_sync;
  logic [1:0]      rxd_sync;
  logic            fe, re, fss, rxd;
  logic [BW-1:0]   bit_cnt;
  logic [N-1:0]    tx_sh;
  logic [N-2:0]    rx_sh;
  logic [N-1:0]    rx_next;
  logic [N-1:0]    rx_word;
  logic            rx_pend;
  logic            oe_b;
  logic            ovr;

  logic            frame_start, last_bit, reload, shift_tx, release_pad;

  logic [N-1:0]    tx_mem [DEPTH];
  logic [AW-1:0]   tx_wr, tx_rd;
  logic [CW-1:0]   tx_count;
  logic [N-1:0]    rx_mem [DEPTH];
  logic [AW-1:0]   rx_wr, rx_rd;
  logic [CW-1:0]   rx_count;

  logic            tx_push, tx_pop, rx_push, rx_pop, rx_drop;
  logic            tx_full, rx_full, rx_empty;

  // Two flops resynchronise each pin; the third clock stage only exists to
  // detect edges, so fss/rxd line up with the strobe that samples them.
  always_ff @(posedge PCLK) begin
    if (CLEAR) begin
      sclk_sync <= '0;
      fss_sync  <= '0;
      rxd_sync  <= '0;
    end else begin
      sclk_sync <= {sclk_sync[1:0], bus.SSPCLKIN};
      fss_sync  <= {fss_sync[0], bus.SSPFSSIN};
      rxd_sync  <= {rxd_sync[0], bus.SSPRXD};
    end
  end

  assign fe      = sclk_sync[2] & ~sclk_sync[1];
  assign re      = ~sclk_sync[2] & sclk_sync[1];
  assign fss     = fss_sync[1];
  assign rxd     = rxd_sync[1];
  assign rx_next = {rx_sh, rxd};

  assign tx_full  = (tx_count == CW'(DEPTH));
  assign rx_full  = (rx_count == CW'(DEPTH));
  assign rx_empty = (rx_count == '0);

  // Frame sequencing. reload marks every point where a new TX word enters
  // the shifter: a fresh frame from IDLE or a back-to-back continuation.
  // A rising edge in IDLE retires the pad after the last bit was held.
  always_comb begin
    state_d     = state_q;
    frame_start = 1'b0;
    last_bit    = 1'b0;
    reload      = 1'b0;
    shift_tx    = 1'b0;
    release_pad = 1'b0;
    case (state_q)
      IDLE: begin
        if (fe && fss) begin
          state_d     = SHIFT;
          frame_start = 1'b1;
          reload      = 1'b1;
        end else if (re) begin
          release_pad = 1'b1;
        end
      end
      SHIFT: begin
        if (fe) begin
          if (bit_cnt == BW'(N - 1)) begin
            last_bit = 1'b1;
            if (fss) reload = 1'b1;
            else     state_d = IDLE;
          end
        end else if (re && bit_cnt != '0) begin
          shift_tx = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // FIFO handshakes; a full FIFO still accepts a push when it pops that cycle.
  always_comb begin
    tx_pop  = reload && (tx_count != '0);
    tx_push = bus.PSEL && bus.PWRITE && (!tx_full || tx_pop);
    rx_pop  = bus.PSEL && !bus.PWRITE && !rx_empty;
    rx_push = rx_pend && (!rx_full || rx_pop);
    rx_drop = rx_pend && rx_full && !rx_pop;
  end

  // Serial datapath and flags. The received word is held one cycle in
  // rx_word so the FIFO push lands one PCLK after the completing edge.
  always_ff @(posedge PCLK) begin
    if (CLEAR) begin
      state_q <= IDLE;
      bit_cnt <= '0;
      tx_sh   <= '0;
      rx_sh   <= '0;
      rx_word <= '0;
      rx_pend <= 1'b0;
      oe_b    <= 1'b1;
      ovr     <= 1'b0;
    end else begin
      state_q <= state_d;
      rx_pend <= last_bit;
      if (reload || last_bit) begin
        bit_cnt <= '0;
      end else if (state_q == SHIFT && fe) begin
        bit_cnt <= bit_cnt + BW'(1);
      end
      if (state_q == SHIFT && fe) begin
        rx_sh <= rx_next[N-2:0];
      end
      if (last_bit) begin
        rx_word <= rx_next;
      end
      if (reload) begin
        tx_sh <= tx_pop ? tx_mem[tx_rd] : '0;
        oe_b  <= 1'b0;
      end else if (shift_tx) begin
        tx_sh <= {tx_sh[N-2:0], 1'b0};
      end else if (release_pad) begin
        tx_sh <= '0;
        oe_b  <= 1'b1;
      end
      if (rx_drop) begin
        ovr <= 1'b1;
      end
    end
  end

  // FIFO storage needs no reset; the counts decide what is valid.
  always_ff @(posedge PCLK) begin
    if (tx_push) tx_mem[tx_wr] <= bus.PWDATA;
    if (rx_push) rx_mem[rx_wr] <= rx_word;
  end

  // FIFO pointers and occupancy counts.
  always_ff @(posedge PCLK) begin
    if (CLEAR) begin
      tx_wr    <= '0;
      tx_rd    <= '0;
      tx_count <= '0;
      rx_wr    <= '0;
      rx_rd    <= '0;
      rx_count <= '0;
    end else begin
      if (tx_push) tx_wr <= tx_wr + AW'(1);
      if (tx_pop)  tx_rd <= tx_rd + AW'(1);
      if (tx_push && !tx_pop)      tx_count <= tx_count + CW'(1);
      else if (!tx_push && tx_pop) tx_count <= tx_count - CW'(1);
      if (rx_push) rx_wr <= rx_wr + AW'(1);
      if (rx_pop)  rx_rd <= rx_rd + AW'(1);
      if (rx_push && !rx_pop)      rx_count <= rx_count + CW'(1);
      else if (!rx_push && rx_pop) rx_count <= rx_count - CW'(1);
    end
  end

  assign bus.SSPTXD    = tx_sh[N-1];
  assign bus.SSPOE_B   = oe_b;
  assign bus.SSPTXINTR = tx_full;
  assign bus.SSPRXINTR = !rx_empty;
  assign bus.SSPRXOVR  = ovr;
  assign bus.PRDATA    = rx_empty ? '0 : rx_mem[rx_rd];

endmodule
